dmem_access_ctrl: RTL

Load/store controller that sits directly upstream of the data memory in the processor's MEM stage. It takes one byte-addressed request at a time and turns it into word-indexed DMEM accesses. Sub-word stores use read-modify-write. Loads are returned sign- or zero-extended. The controller registers every DMEM control signal and sequences them so that the DMEM write strobe rises only after address and data have been stable for a full cycle, because DMEM commits on the rising edge of its write strobe.

---
 rtl/dmem_access_ctrl_if.sv | 25 ++
 rtl/dmem_access_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl_if.sv
// Request/response bus between the MEM stage and the DMEM access controller.
// The master issues one byte-addressed request at a time; the slave answers
// with a single-cycle completion pulse.
interface dmem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Load/store controller in front of a 256-word DMEM. Converts byte-addressed
// requests into word accesses, does read-modify-write for sub-word stores and
// sign/zero-extends loads. Every DMEM control output comes straight from a
// flop; the write strobe is sequenced so address and data are settled a full
// cycle before it rises (DMEM commits on the strobe's rising edge).
module dmem_access_ctrl (
    input  logic                 clk,
    input  logic                 rst_n,
    dmem_access_ctrl_if.slave    bus,
    output logic [31:0]          DMEM_address,
    output logic [31:0]          DMEM_data_in,
    output logic                 DMEM_mem_write,
    output logic                 DMEM_mem_read,
    input  logic [31:0]          DMEM_data_out
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_SETUP, S_PULSE, S_RESP} state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    state_e      state, state_next;
    logic        wr_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic        accept;
    logic        req_err;

    // Upper address bits alias modulo 1 KiB and are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[31:10];

    assign accept = (state == S_IDLE) && bus.req_valid;

    // Pick the addressed lane out of a DMEM word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace only the addressed lane of the word read back from DMEM.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane);
        logic [31:0] r;
        r = word;
        if (size == SZ_BYTE)
            r[{lane, 3'b000} +: 8] = wdata[7:0];
        else if (lane[1])
            r[31:16] = wdata[15:0];
        else
            r[15:0] = wdata[15:0];
        return r;
    endfunction

    // Alignment / size legality of the incoming request.
    always_comb begin
        req_err = (bus.req_size == SZ_BAD)
               || (bus.req_size == SZ_HALF && bus.req_addr[0])
               || (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state sequencing for load, word store, sub-word RMW and error paths.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch
        // is inferred.
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_next = S_RESP;
                    else if (bus.req_write && bus.req_size == SZ_WORD)
                        state_next = S_SETUP;
                    else
                        state_next = S_RD;
                end
            end
            S_RD:    state_next = wr_q ? S_SETUP : S_RESP;
            S_SETUP: state_next = S_PULSE;
            S_PULSE: state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Registered outputs and request datapath; strobes are loaded from the
    // next-state decode so they are clean flop outputs aligned with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q           <= 1'b0;
            uns_q          <= 1'b0;
            size_q         <= 2'b00;
            lane_q         <= 2'b00;
            wdata_q        <= 32'b0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'b0;
            bus.resp_err   <= 1'b0;
            DMEM_address   <= 32'b0;
            DMEM_data_in   <= 32'b0;
            DMEM_mem_write <= 1'b0;
            DMEM_mem_read  <= 1'b0;
        end else begin
            bus.req_ready  <= (state_next == S_IDLE);
            bus.resp_valid <= (state_next == S_RESP);
            DMEM_mem_read  <= (state_next == S_RD);
            DMEM_mem_write <= (state_next == S_PULSE);

            if (accept) begin
                wr_q         <= bus.req_write;
                uns_q        <= bus.req_unsigned;
                size_q       <= bus.req_size;
                lane_q       <= bus.req_addr[1:0];
                wdata_q      <= bus.req_wdata;
                DMEM_address <= {24'b0, bus.req_addr[9:2]};
                bus.resp_err <= req_err;
            end

            if (state == S_RD && !wr_q)
                bus.resp_rdata <= load_extract(DMEM_data_out, size_q, lane_q, uns_q);

            // Word stores come straight from the request; sub-word stores
            // merge into the word read during RD. Held until the next SETUP.
            if (state_next == S_SETUP)
                DMEM_data_in <= (state == S_RD)
                              ? store_merge(DMEM_data_out, wdata_q, size_q, lane_q)
                              : bus.req_wdata;

            if (state == S_RESP) begin
                bus.resp_rdata <= 32'b0;
                bus.resp_err   <= 1'b0;
            end
        end
    end

endmodule
